// File: rtl/nios2_keys_pkg.sv
// Shared definitions for the nios2_keys input PIO: register word
// addresses, edge-type encodings and small helper functions.
package nios2_keys_pkg;

  // Word addresses on the Avalon-MM slave.
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE    = 2'd3;

  // Encodings of the EDGE_TYPE parameter.
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Debounce counter width: enough to hold DEBOUNCE_CYCLES-1, never less
  // than one bit (DEBOUNCE_CYCLES of 1 or 2 still needs a register).
  function automatic int cnt_width(input int cycles);
    if (cycles <= 2) begin
      return 1;
    end
    return $clog2(cycles);
  endfunction

  // Edge qualifier for one bit: cur is the debounced level this cycle,
  // prev the same level one cycle earlier. Unknown encodings behave as
  // "any edge" so a bad parameter never silently disables capture.
  function automatic logic edge_bit(input logic cur, input logic prev,
                                    input int etype);
    case (etype)
      EDGE_RISE: return cur & ~prev;
      EDGE_FALL: return ~cur & prev;
      default:   return cur ^ prev;
    endcase
  endfunction

endpackage

// File: rtl/nios2_keys_debounce.sv
// One input bit: two-flop synchroniser followed by a debounce counter.
// The debounced level (stable_o) only follows the synchronised input once
// the two have disagreed for DEBOUNCE_CYCLES consecutive cycles; a single
// cycle of agreement restarts the count.
module nios2_keys_debounce
  import nios2_keys_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic in_i,
  output logic stable_o
);

  localparam int                CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next-state for the debounced level and its agreement counter.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchroniser, debounced level and counter registers; reset parks
  // everything at the idle level so no edge is seen on reset release.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= IDLE_LEVEL;
      sync2_q  <= IDLE_LEVEL;
      stable_q <= IDLE_LEVEL;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= in_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/nios2_keys.sv
// Avalon-MM input PIO for push-buttons/switches. Each input bit is
// synchronised and debounced; edges on the debounced level are caught in
// a sticky write-1-to-clear EDGECAPTURE register, and any captured bit
// that is also enabled in IRQMASK raises the level interrupt.
//
// Bus handshake: a write is accepted on the clk edge where chipselect=1
// and write_n=0; there are no wait states. readdata is a pure function of
// address and the registers, so reads never have side effects.
module nios2_keys
  import nios2_keys_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int IDLE_LEVEL      = 1,
  parameter int EDGE_TYPE       = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic IDLE_BIT = (IDLE_LEVEL != 0);

  logic [WIDTH-1:0] stable;
  // Debounced level delayed by one cycle; resets equal to the debounced
  // level so nothing is captured right after reset.
  logic [WIDTH-1:0] stable_prev_q;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] irqmask_q;
  logic [WIDTH-1:0] irqmask_d;
  logic [WIDTH-1:0] edgecap_q;
  logic [WIDTH-1:0] edgecap_d;
  logic             wr_en;

  assign wr_en = chipselect & ~write_n;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    nios2_keys_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .IDLE_LEVEL     (IDLE_BIT)
    ) u_debounce (
      .clk     (clk),
      .reset   (reset),
      .in_i    (in_port[g]),
      .stable_o(stable[g])
    );

    assign edge_det[g] = edge_bit(stable[g], stable_prev_q[g], EDGE_TYPE);
  end

  // Writedata bits above WIDTH have no register behind them.
  if (WIDTH < 32) begin : g_wdata_hi
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^writedata[31:WIDTH];
  end

  // Register next-state: mask write, then W1C clear, then new edges OR'd
  // in last so a same-cycle edge always wins over the clear.
  always_comb begin
    irqmask_d = irqmask_q;
    edgecap_d = edgecap_q;
    if (wr_en && (address == ADDR_IRQMASK)) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && (address == ADDR_EDGE)) begin
      edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
    end
    edgecap_d = edgecap_d | edge_det;
  end

  // Software-visible registers and the edge-detect delay stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_prev_q <= {WIDTH{IDLE_BIT}};
      irqmask_q     <= '0;
      edgecap_q     <= '0;
    end else begin
      stable_prev_q <= stable;
      irqmask_q     <= irqmask_d;
      edgecap_q     <= edgecap_d;
    end
  end

  // Read mux; unimplemented bits and the reserved word read as zero.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = stable;
      ADDR_RSVD:    readdata = '0;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask_q;
      ADDR_EDGE:    readdata[WIDTH-1:0] = edgecap_q;
      default:      readdata = '0;
    endcase
  end

  assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_nios2_keys.sv
// Testbench for nios2_keys with WIDTH=4, DEBOUNCE_CYCLES=4, falling-edge
// capture and idle-high keys. A table of per-cycle bus/input records is
// played first, followed by hand-written sequences for glitch rejection,
// W1C behaviour, set-wins-over-clear and reset in the middle of a count.
module tb_nios2_keys;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  nios2_keys #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(4),
    .IDLE_LEVEL     (1),
    .EDGE_TYPE      (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  // Clock: 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per cycle: inputs driven for that cycle and the readdata /
  // irq expected before the cycle's closing clock edge.
  typedef struct {
    logic [3:0]  in_v;
    logic        cs;
    logic        wr_n;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a,
                        input logic [31:0] exp);
    address = a;
    #1;
    check(name, readdata, exp);
  endtask

  task automatic irq_chk(input string name, input logic exp);
    check(name, {31'b0, irq}, {31'b0, exp});
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  initial begin
    // Table: falling edge on bit 0, DATA/EDGECAPTURE latency, mask write,
    // ignored DATA write, W1C clear of bit 0.
    //            in     cs    wr_n  addr  wdata  exp_rd irq
    vecs[0]  = '{4'hE, 1'b0, 1'b1, 2'd0, 32'h0, 32'hF, 1'b0};
    vecs[1]  = '{4'hE, 1'b0, 1'b1, 2'd0, 32'h0, 32'hF, 1'b0};
    vecs[2]  = '{4'hE, 1'b0, 1'b1, 2'd0, 32'h0, 32'hF, 1'b0};
    vecs[3]  = '{4'hE, 1'b0, 1'b1, 2'd0, 32'h0, 32'hF, 1'b0};
    vecs[4]  = '{4'hE, 1'b0, 1'b1, 2'd0, 32'h0, 32'hF, 1'b0};
    vecs[5]  = '{4'hE, 1'b0, 1'b1, 2'd3, 32'h0, 32'h0, 1'b0};
    vecs[6]  = '{4'hE, 1'b0, 1'b1, 2'd0, 32'h0, 32'hE, 1'b0};
    vecs[7]  = '{4'hE, 1'b0, 1'b1, 2'd3, 32'h0, 32'h1, 1'b0};
    vecs[8]  = '{4'hE, 1'b1, 1'b0, 2'd2, 32'h1, 32'h0, 1'b0};
    vecs[9]  = '{4'hE, 1'b0, 1'b1, 2'd2, 32'h0, 32'h1, 1'b1};
    vecs[10] = '{4'hE, 1'b1, 1'b0, 2'd0, 32'h0, 32'hE, 1'b1};
    vecs[11] = '{4'hE, 1'b0, 1'b1, 2'd1, 32'h0, 32'h0, 1'b1};
    vecs[12] = '{4'hE, 1'b1, 1'b0, 2'd3, 32'h1, 32'h1, 1'b1};
    vecs[13] = '{4'hE, 1'b0, 1'b1, 2'd3, 32'h0, 32'h0, 1'b0};

    // Reset.
    reset      = 1'b1;
    in_port    = 4'hF;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    repeat (3) tick();
    reset = 1'b0;
    rd_chk("reset_data", 2'd0, 32'hF);
    rd_chk("reset_mask", 2'd2, 32'h0);
    rd_chk("reset_edge", 2'd3, 32'h0);
    irq_chk("reset_irq", 1'b0);

    // Table-driven cycles.
    for (int i = 0; i < 14; i++) begin
      in_port    = vecs[i].in_v;
      chipselect = vecs[i].cs;
      write_n    = vecs[i].wr_n;
      address    = vecs[i].addr;
      writedata  = vecs[i].wdata;
      #1;
      check($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
      irq_chk($sformatf("vec%0d_irq", i), vecs[i].exp_irq);
      tick();
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;

    // Release bit 0 (rising edge, not captured) then a 3-cycle glitch on bit 1.
    in_port = 4'hF;
    repeat (8) tick();
    rd_chk("release_data", 2'd0, 32'hF);
    rd_chk("release_edge", 2'd3, 32'h0);
    in_port = 4'hD;
    repeat (3) tick();
    in_port = 4'hF;
    repeat (8) tick();
    rd_chk("glitch_data", 2'd0, 32'hF);
    rd_chk("glitch_edge", 2'd3, 32'h0);

    // A 4-cycle low pulse on bit 1 is long enough to flip it, then back.
    in_port = 4'hD;
    repeat (4) tick();
    in_port = 4'hF;
    repeat (2) tick();
    rd_chk("pulse4_data_low", 2'd0, 32'hD);
    repeat (5) tick();
    rd_chk("pulse4_data_back", 2'd0, 32'hF);
    rd_chk("pulse4_edge", 2'd3, 32'h2);
    irq_chk("pulse4_irq_masked", 1'b0);

    // Build EDGECAPTURE=0x3 with IRQMASK=0x3, then clear one bit at a time.
    in_port = 4'hE;
    repeat (8) tick();
    rd_chk("two_edge", 2'd3, 32'h3);
    bus_wr(2'd2, 32'h3);
    rd_chk("two_mask", 2'd2, 32'h3);
    irq_chk("two_irq", 1'b1);
    bus_wr(2'd3, 32'h1);
    rd_chk("w1c_bit0_edge", 2'd3, 32'h2);
    irq_chk("w1c_bit0_irq", 1'b1);
    bus_wr(2'd3, 32'h2);
    rd_chk("w1c_bit1_edge", 2'd3, 32'h0);
    irq_chk("w1c_bit1_irq", 1'b0);
    in_port = 4'hF;
    repeat (8) tick();
    rd_chk("w1c_release_edge", 2'd3, 32'h0);

    // Falling edge on bit 2 lands in the same cycle as a W1C of bit 2.
    in_port = 4'hB;
    repeat (6) tick();
    rd_chk("setwins_data", 2'd0, 32'hB);
    rd_chk("setwins_pre_edge", 2'd3, 32'h0);
    bus_wr(2'd3, 32'h4);
    rd_chk("setwins_edge", 2'd3, 32'h4);
    irq_chk("setwins_irq", 1'b0);
    in_port = 4'hF;
    repeat (8) tick();
    rd_chk("setwins_hold_edge", 2'd3, 32'h4);

    // Reset while bit 3 is two counts into its debounce.
    in_port = 4'h7;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd_chk("midreset_data", 2'd0, 32'hF);
    rd_chk("midreset_mask", 2'd2, 32'h0);
    rd_chk("midreset_edge", 2'd3, 32'h0);
    irq_chk("midreset_irq", 1'b0);
    repeat (5) tick();
    rd_chk("midreset_data_wait", 2'd0, 32'hF);
    tick();
    rd_chk("midreset_data_flip", 2'd0, 32'h7);
    rd_chk("midreset_edge_pre", 2'd3, 32'h0);
    tick();
    rd_chk("midreset_edge_cap", 2'd3, 32'h8);
    irq_chk("midreset_irq_end", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nios2_keys.md
# nios2_keys

Avalon-MM memory-mapped input port for the Nios II system: samples push-buttons/switches on `in_port`, synchronises and debounces each bit, and captures edges into a sticky register that can raise a maskable interrupt. It is the input-direction counterpart of the LED output PIO. It sits on the same system interconnect with the same 2-bit word address, chipselect, write_n and 32-bit data conventions. The debounced value, interrupt mask and edge-capture flags are software-visible.

## Interface
Parameters:
- `WIDTH`, 4: number of input bits (1..32).
- `DEBOUNCE_CYCLES`, 50000: consecutive cycles a synchronised input must differ from the debounced state before the state flips (≥1; 1 ms at 50 MHz).
- `IDLE_LEVEL`, 1: reset value of every debounced bit (keys are active-low, idle high).
- `EDGE_TYPE`, 1: edge that sets a capture bit: 0 = rising, 1 = falling, 2 = any.

Ports:
- `clk`, in, 1: system clock; only clock.
- `reset`, in, 1: synchronous, active-high reset.
- `address`, in, 2: word address.
- `chipselect`, in, 1: slave select.
- `write_n`, in, 1: active-low write strobe.
- `writedata`, in, 32: write data.
- `readdata`, out, 32: read data, combinational from address; zero wait states.
- `in_port`, in, WIDTH: asynchronous external inputs.
- `irq`, out, 1: level interrupt request.

## Operation
Register map (word addresses):
- 0 DATA: read-only debounced state in bits [WIDTH-1:0]. Writes are ignored.
- 1 reserved: reads 0, writes ignored.
- 2 IRQMASK: read/write, bits [WIDTH-1:0].
- 3 EDGECAPTURE: read; a write clears each bit whose writedata bit is 1 (write-1-to-clear).
- Bits above WIDTH read 0.

Datapath, per bit:
- Two-flop synchroniser produces `sync`.
- Debounce counter:
  - If `sync == stable`, the counter is 0.
  - Otherwise, when the counter equals DEBOUNCE_CYCLES-1, `stable` ← `sync` and the counter ← 0.
  - Otherwise the counter increments.
  - A single cycle of agreement restarts the count.
  - Counter width is $clog2(DEBOUNCE_CYCLES) with a minimum of 1.
- `stable_d` registers `stable`; an edge is defined on `stable` vs `stable_d` per EDGE_TYPE.
- EDGECAPTURE bit sets on an edge and stays set until cleared.
- If a W1C write and a new edge hit the same bit in the same cycle, set wins.
- `irq` = |(EDGECAPTURE & IRQMASK), combinational from registers.

Reset values:
- sync flops, `stable` and `stable_d`: IDLE_LEVEL.
- Counters: 0.
- IRQMASK and EDGECAPTURE: 0.
- `irq`: 0.
- `readdata` follows the address, so address 0 reads IDLE_LEVEL bits.
- Reset asserted mid-debounce discards the count.
- No spurious edge after reset, because `stable_d` resets equal to `stable`.

## Timing
- A write takes effect at the clk edge where chipselect=1 and write_n=0. The new IRQMASK is visible on `readdata` and `irq` in the next cycle.
- An input change is sampled at edge 0.
  - `sync` changes after edge 2.
  - `stable` changes at edge DEBOUNCE_CYCLES+2.
  - EDGECAPTURE and `irq` change at edge DEBOUNCE_CYCLES+3.
- A pulse shorter than DEBOUNCE_CYCLES synchronised cycles never changes `stable`.
- A W1C clear drops `irq` in the next cycle, unless a same-cycle edge re-sets the bit.
- Reads have no side effects.

## Structure
- Shared package `nios2_keys_pkg`:
  - address constants ADDR_DATA = 0, ADDR_IRQMASK = 2, ADDR_EDGE = 3.
  - EDGE_TYPE encodings EDGE_RISE, EDGE_FALL, EDGE_ANY.
- Sub-module `nios2_keys_debounce`: one bit holding the synchroniser, counter and `stable`, with parameters DEBOUNCE_CYCLES and IDLE_LEVEL. It is instantiated WIDTH times in a generate loop.
- The top level holds the edge detect, registers, read mux and irq.

## Test plan
Bench parameters: WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=1, IDLE_LEVEL=1.
- Reset, then read address 0 → 0x0000000F; reads of addresses 2 and 3 → 0; `irq`=0.
- Drive in_port=4'b1110 held → DATA reads 0xE from edge 6 on and EDGECAPTURE reads 0x1 from edge 7. `irq` stays 0 because the mask is 0. Write IRQMASK=0x1 → `irq`=1 in the next cycle.
- Glitch bit 1 low for 3 cycles, then release → DATA unchanged at 0xF and EDGECAPTURE unchanged. A 4-cycle low pulse does flip the bit.
- With EDGECAPTURE=0x3 and IRQMASK=0x3, write 0x1 to address 3 → reads 0x2 and `irq` stays 1. Write 0x2 → reads 0 and `irq`=0.
- Arrange a W1C write to bit 2 in the same cycle as a falling edge on bit 2 → EDGECAPTURE bit 2 remains 1.
- Assert `reset` for 1 cycle while bit 3 is mid-count (counter=2) → count restarts; DATA returns to 0xF and EDGECAPTURE to 0 with no capture. Releasing the held input afterwards requires a full 4-cycle count.
